game_flow_ctrl: RTL and testbench

Parametrised game-flow controller that sits between World and Output. It sequences title, fade-in, play, fade-out, hold, game-over and win phases across STAGES levels and LIVES attempts. It drives the world's reset and run enable, the current stage index and lives count, and a 12-bit RGB intensity mask that Output applies per channel for screen fades.

---
 rtl/game_pkg.sv | 17 +
 rtl/game_flow_ctrl_frame_timer.sv | 19 +
 rtl/game_flow_ctrl.sv | 122 ++++++++++++
 tb/tb_game_flow_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, world status codes and fade mask constants for the game-flow controller
package game_pkg;
  typedef enum logic [2:0] {
    TITLE,
    FADE_IN,
    PLAY,
    FADE_OUT,
    HOLD,
    GAMEOVER,
    WIN
  } state_t;
  localparam logic [1:0] OVER_NONE = 2'b00;
  localparam logic [1:0] OVER_DIED = 2'b01;
  localparam logic [1:0] OVER_CLEAR = 2'b10;
  localparam logic [11:0] MASK_FULL = 12'hFFF;
  localparam logic [11:0] MASK_BLACK = 12'h000;
endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// frame_timer: loadable down-counter stepped by frame ticks; done flags the tick that brings it to zero
module frame_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rstn) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = tick && cnt == W'(1);
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: title/fade/play/hold/game-over/win sequencer driving World reset+run, stage, lives and RGB fade mask (GAMECTRL_FADE_EN enables fades)
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int LIVES = 3,
  parameter int HOLD_FRAMES = 60,
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int LW = $clog2(LIVES + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          frame_tick,
  input  logic          start,
  input  logic [1:0]    over,
  output logic          world_rstn,
  output logic          run,
  output logic [SW-1:0] stage,
  output logic [LW-1:0] lives,
  output logic [11:0]   mask,
  output logic [2:0]    state
);
`ifdef GAMECTRL_FADE_EN
  localparam logic [3:0] LVL_START = 4'h0;
`else
  localparam logic [3:0] LVL_START = 4'hF;
`endif
  state_t st, st_n;
  logic [SW-1:0] stage_n;
  logic [LW-1:0] lives_n;
  logic [3:0] lvl, lvl_n;
  logic cause, cause_n, load, done;
  frame_timer #(.W(10)) u_timer (
    .clk(clk),
    .rstn(rstn),
    .tick(frame_tick && st == HOLD),
    .load(load),
    .load_val(10'(HOLD_FRAMES)),
    .done(done)
  );
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st <= TITLE;
      stage <= '0;
      lives <= LW'(LIVES);
      lvl <= 4'hF;
      cause <= 1'b0;
      world_rstn <= 1'b0;
      run <= 1'b0;
    end else begin
      st <= st_n;
      stage <= stage_n;
      lives <= lives_n;
      lvl <= lvl_n;
      cause <= cause_n;
      world_rstn <= !(st_n inside {TITLE, HOLD, GAMEOVER, WIN});
      run <= st_n == PLAY;
    end
  end
  // cause: 1 = stage cleared, 0 = died
  always_comb begin
    st_n = st;
    stage_n = stage;
    lives_n = lives;
    lvl_n = lvl;
    cause_n = cause;
    load = 1'b0;
    case (st)
      TITLE: if (start) begin
        st_n = FADE_IN;
        lvl_n = LVL_START;
      end
`ifdef GAMECTRL_FADE_EN
      FADE_IN: if (frame_tick) begin
        lvl_n = lvl + 1'b1;
        st_n = (lvl == 4'hE) ? PLAY : FADE_IN;
      end
      FADE_OUT: if (frame_tick) begin
        lvl_n = lvl - 1'b1;
        load = lvl == 4'h1;
        st_n = load ? HOLD : FADE_OUT;
      end
`else
      FADE_IN: st_n = PLAY;
      FADE_OUT: begin
        st_n = HOLD;
        load = 1'b1;
      end
`endif
      // death checked first so 11 counts as died
      PLAY: if (over[0]) begin
        lives_n = lives - 1'b1;
        cause_n = 1'b0;
        st_n = FADE_OUT;
      end else if (over == OVER_CLEAR) begin
        cause_n = 1'b1;
        st_n = FADE_OUT;
      end
      HOLD: if (done) begin
        if (cause && stage == SW'(STAGES - 1)) begin
          st_n = WIN;
          lvl_n = 4'hF;
        end else if (!cause && lives == '0) begin
          st_n = GAMEOVER;
          lvl_n = 4'hF;
        end else begin
          st_n = FADE_IN;
          stage_n = cause ? stage + 1'b1 : stage;
        end
      end
      GAMEOVER, WIN: if (start) begin
        st_n = FADE_IN;
        stage_n = '0;
        lives_n = LW'(LIVES);
        lvl_n = LVL_START;
      end
      default: st_n = TITLE;
    endcase
  end
  assign mask = {lvl, lvl, lvl};
  assign state = st;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed self-checking bench for game_flow_ctrl (expectations follow GAMECTRL_FADE_EN if defined)
module tb_game_flow_ctrl;
  import game_pkg::*;
`ifdef GAMECTRL_FADE_EN
  localparam int M0 = 'h000;
`else
  localparam int M0 = 'hFFF;
`endif
  logic clk = 0, rstn = 0, frame_tick = 0, start = 0;
  logic [1:0] over = 0;
  logic world_rstn, run;
  logic [0:0] stage;
  logic [1:0] lives;
  logic [11:0] mask;
  logic [2:0] state;
  int checks = 0, errors = 0;
  game_flow_ctrl dut (
    .clk(clk),
    .rstn(rstn),
    .frame_tick(frame_tick),
    .start(start),
    .over(over),
    .world_rstn(world_rstn),
    .run(run),
    .stage(stage),
    .lives(lives),
    .mask(mask),
    .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 'h%0h exp 'h%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    frame_tick = 1;
    cyc();
    frame_tick = 0;
  endtask
  task automatic to_play();
`ifdef GAMECTRL_FADE_EN
    repeat (14) tick();
    chk("fade_in_st", int'(state), int'(FADE_IN));
    chk("fade_in_mask", int'(mask), 'hEEE);
    tick();
`else
    cyc();
`endif
    chk("play_st", int'(state), int'(PLAY));
    chk("play_mask", int'(mask), 'hFFF);
    chk("play_run", int'(run), 1);
  endtask
  task automatic fade_out(input int n);
`ifdef GAMECTRL_FADE_EN
    repeat (n - 1) tick();
    chk("fade_out_mask", int'(mask), 'h111);
    chk("fade_out_run", int'(run), 0);
    tick();
`else
    if (n > 0) cyc();
`endif
    chk("hold_st", int'(state), int'(HOLD));
    chk("hold_mask", int'(mask), M0);
    chk("hold_wrstn", int'(world_rstn), 0);
  endtask
  task automatic hold();
    repeat (59) tick();
    chk("hold_59", int'(state), int'(HOLD));
    tick();
  endtask
  task automatic die(input logic [1:0] code, input int exp_lives);
    over = code;
    cyc();
    over = 0;
    chk("die_st", int'(state), int'(FADE_OUT));
    chk("die_lives", int'(lives), exp_lives);
    chk("die_run", int'(run), 0);
  endtask
  initial begin
    cyc();
    rstn = 1;
    chk("rst_st", int'(state), int'(TITLE));
    chk("rst_mask", int'(mask), 'hFFF);
    chk("rst_wrstn", int'(world_rstn), 0);
    chk("rst_run", int'(run), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_stage", int'(stage), 0);
    tick();
    chk("title_tick", int'(state), int'(TITLE));
    start = 1;
    cyc();
    start = 0;
    chk("start_st", int'(state), int'(FADE_IN));
    chk("start_wrstn", int'(world_rstn), 1);
    chk("start_mask", int'(mask), M0);
    to_play();
    die(2'b01, 2);
    fade_out(15);
    hold();
    chk("died_st", int'(state), int'(FADE_IN));
    chk("died_stage", int'(stage), 0);
    chk("died_wrstn", int'(world_rstn), 1);
    to_play();
    over = 2'b10;
    cyc();
    over = 0;
    chk("clr_st", int'(state), int'(FADE_OUT));
    chk("clr_lives", int'(lives), 2);
    fade_out(15);
    hold();
    chk("clr1_st", int'(state), int'(FADE_IN));
    chk("clr1_stage", int'(stage), 1);
    to_play();
    over = 2'b10;
    cyc();
    over = 0;
    fade_out(15);
    hold();
    chk("win_st", int'(state), int'(WIN));
    chk("win_mask", int'(mask), 'hFFF);
    chk("win_wrstn", int'(world_rstn), 0);
    start = 1;
    cyc();
    start = 0;
    chk("win_start_st", int'(state), int'(FADE_IN));
    chk("win_start_stage", int'(stage), 0);
    chk("win_start_lives", int'(lives), 3);
    to_play();
    die(2'b01, 2);
    fade_out(15);
    hold();
    to_play();
    over = 2'b11;
    frame_tick = 1;
    cyc();
    over = 0;
    frame_tick = 0;
    chk("d11_st", int'(state), int'(FADE_OUT));
    chk("d11_lives", int'(lives), 1);
    chk("d11_mask", int'(mask), 'hFFF);
`ifdef GAMECTRL_FADE_EN
    tick();
    chk("d11_tick_mask", int'(mask), 'hEEE);
    fade_out(14);
`else
    fade_out(1);
`endif
    hold();
    chk("d2_st", int'(state), int'(FADE_IN));
    to_play();
    die(2'b01, 0);
    fade_out(15);
    hold();
    chk("go_st", int'(state), int'(GAMEOVER));
    chk("go_lives", int'(lives), 0);
    chk("go_mask", int'(mask), 'hFFF);
    chk("go_wrstn", int'(world_rstn), 0);
    start = 1;
    cyc();
    start = 0;
    chk("go_start_st", int'(state), int'(FADE_IN));
    chk("go_start_lives", int'(lives), 3);
    chk("go_start_mask", int'(mask), M0);
    to_play();
    start = 1;
    cyc();
    start = 0;
    chk("play_start_ign", int'(state), int'(PLAY));
    tick();
    chk("play_tick_ign", int'(mask), 'hFFF);
    die(2'b01, 2);
`ifdef GAMECTRL_FADE_EN
    repeat (3) tick();
    chk("mid_fade_mask", int'(mask), 'hCCC);
`endif
    rstn = 0;
    cyc();
    rstn = 1;
    chk("mrst_st", int'(state), int'(TITLE));
    chk("mrst_mask", int'(mask), 'hFFF);
    chk("mrst_wrstn", int'(world_rstn), 0);
    chk("mrst_lives", int'(lives), 3);
    chk("mrst_stage", int'(stage), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
